// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// column-sample classification and matrix dimensions.
package keypad_scanner_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  typedef enum logic [1:0] {
    SMP_RELEASED,
    SMP_PRESSED,
    SMP_INVALID
  } sample_e;

  // Index of the lowest zero bit; only meaningful when exactly one bit is 0.
  function automatic logic [1:0] zero_index(input logic [COLS-1:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Slot timer: free-running modulo-SCAN_DIV counter, tick high on the last
// cycle of every slot. Shared with the 7-segment digit scanner.
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (slot_q == LAST) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + W'(1);
    end
  end

  assign tick = (slot_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows active-low, samples synchronized
// columns once per slot, and emits one debounced event per key press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic             tick;
  logic [3:0]       col_meta_q, col_s_q;
  state_e           state_q;
  logic [3:0]       row_q;
  logic [1:0]       row_idx_q, col_idx_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [3:0]       key_code_q;
  logic             key_valid_q, key_down_q;
  logic [2:0]       n_zero;
  sample_e          smp;
  logic [1:0]       smp_col;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  // Multiple simultaneous keys on one row are rejected rather than guessed.
  always_comb begin
    n_zero  = 3'($countones(~col_s_q));
    smp_col = zero_index(col_s_q);
    if (n_zero == 3'd0)      smp = SMP_RELEASED;
    else if (n_zero == 3'd1) smp = SMP_PRESSED;
    else                     smp = SMP_INVALID;
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          ST_SCAN: begin
            if (smp == SMP_PRESSED) begin
              col_idx_q <= smp_col;
              cnt_q     <= CNT_W'(1);
              state_q   <= ST_DEBOUNCE;
            end else begin
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (smp == SMP_PRESSED && smp_col == col_idx_q) begin
              if (cnt_inc == CNT_MAX) begin
                key_code_q  <= {row_idx_q, col_idx_q};
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= ST_HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // A broken run abandons this row and resumes scanning at once.
              cnt_q     <= '0;
              state_q   <= ST_SCAN;
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
            end
          end
          ST_HELD: begin
            if (smp == SMP_RELEASED) begin
              if (cnt_inc == CNT_MAX) begin
                key_down_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= ST_SCAN;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix
// and a scoreboard of expected key codes consumed on each key_valid pulse.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [3:0] keys [4];
  logic [3:0] exp_q [$];
  int tests_run = 0;
  int failures  = 0;
  int pulse_count = 0;
  logic prev_valid = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~keys[r];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests_run++;
      if ($countones(~row) != 1) begin
        failures++;
        $display("FAIL row_onehot: row=%b, required exactly one low bit", row);
      end
      if (key_valid) begin
        pulse_count++;
        $display("[TB] key event code=%h down=%b", key_code, key_down);
        tests_run++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: code=%h, required no pulse", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code !== e) begin
            failures++;
            $display("FAIL key_code: got %h, required %h", key_code, e);
          end
        end
        tests_run++;
        if (key_down !== 1'b1) begin
          failures++;
          $display("FAIL down_with_valid: key_down=%b, required 1", key_down);
        end
        tests_run++;
        if (prev_valid) begin
          failures++;
          $display("FAIL valid_width: key_valid high 2 cycles, required 1");
        end
      end
    end
    prev_valid = key_valid;
  end

  task automatic wait_row_fresh(input logic [3:0] target);
    int ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (row !== target) begin ok = 1; break; end
    end
    if (ok == 1) begin
      ok = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (row === target) begin ok = 1; break; end
      end
    end
    tests_run++;
    if (ok != 1) begin
      failures++;
      $display("FAIL row_timeout: row=%b, required to reach %b", row, target);
    end
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_valid) begin n = i; break; end
    end
  endtask

  task automatic wait_down(input logic level, input int budget, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_down === level) begin ok = 1; break; end
    end
    tests_run++;
    if (ok != 1) begin
      failures++;
      $display("FAIL %s: key_down=%b, required %b within %0d cycles", name, key_down, level, budget);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (row !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: row=%b code=%h valid=%b down=%b, required 1110 0 0 0",
               row, key_code, key_valid, key_down);
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_row = 4'b1111;
      exp_row[(k / 4) % 4] = 1'b0;
      tests_run++;
      if (row !== exp_row || key_valid !== 1'b0 || key_down !== 1'b0) begin
        failures++;
        $display("FAIL idle_scan cycle %0d: row=%b valid=%b down=%b, required %b 0 0",
                 k, row, key_valid, key_down, exp_row);
      end
    end
  endtask

  task automatic test_single_key();
    int start, n;
    start = pulse_count;
    exp_q.push_back(4'h9);
    keys[2][1] = 1'b1;
    wait_pulse(200, n);
    tests_run++;
    if (n < 0) begin
      failures++;
      $display("FAIL single_key_timeout: no key_valid, required one within 200 cycles");
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (row !== 4'b1011 || key_down !== 1'b1 || pulse_count - start != 1) begin
      failures++;
      $display("FAIL single_key_hold: row=%b down=%b pulses=%0d, required 1011 1 1",
               row, key_down, pulse_count - start);
    end
    keys[2][1] = 1'b0;
    wait_down(1'b0, 200, "single_key_release");
  endtask

  task automatic test_bounce();
    int start, n;
    start = pulse_count;
    wait_row_fresh(4'b1011);
    keys[2][1] = 1'b1;
    repeat (4) @(negedge clk);
    keys[2][1] = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (row !== 4'b0111 || pulse_count != start) begin
      failures++;
      $display("FAIL bounce_break: row=%b pulses=%0d, required 0111 0", row, pulse_count - start);
    end
    exp_q.push_back(4'h9);
    keys[2][1] = 1'b1;
    wait_pulse(200, n);
    tests_run++;
    if (n != 24) begin
      failures++;
      $display("FAIL bounce_latency: pulse after %0d cycles, required 24", n);
    end
    keys[2][1] = 1'b0;
    wait_down(1'b0, 200, "bounce_release");
    tests_run++;
    if (pulse_count - start != 1) begin
      failures++;
      $display("FAIL bounce_count: %0d pulses, required 1", pulse_count - start);
    end
  endtask

  task automatic test_two_keys();
    int start, n;
    logic [3:0] seen;
    start = pulse_count;
    seen = 4'h0;
    keys[1][0] = 1'b1;
    keys[1][3] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) if (!row[r]) seen[r] = 1'b1;
    end
    tests_run++;
    if (seen !== 4'hF || pulse_count != start) begin
      failures++;
      $display("FAIL two_keys_scan: rows seen=%b pulses=%0d, required 1111 0", seen, pulse_count - start);
    end
    exp_q.push_back(4'h4);
    keys[1][3] = 1'b0;
    wait_pulse(200, n);
    tests_run++;
    if (n < 0 || key_code !== 4'h4) begin
      failures++;
      $display("FAIL two_keys_single: wait=%0d code=%h, required pulse with 4", n, key_code);
    end
    keys[1][0] = 1'b0;
    wait_down(1'b0, 200, "two_keys_release");
  endtask

  task automatic test_release_glitch();
    int n;
    exp_q.push_back(4'h9);
    keys[2][1] = 1'b1;
    wait_pulse(200, n);
    tests_run++;
    if (n < 0) begin
      failures++;
      $display("FAIL glitch_press_timeout: no key_valid, required one");
    end
    keys[2][1] = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (key_down !== 1'b1) begin
      failures++;
      $display("FAIL glitch_early_2: key_down=%b, required 1", key_down);
    end
    keys[2][1] = 1'b1;
    repeat (4) @(negedge clk);
    keys[2][1] = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (key_down !== 1'b1) begin
      failures++;
      $display("FAIL glitch_early_5: key_down=%b, required 1", key_down);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (key_down !== 1'b0 || row !== 4'b1011 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL glitch_release: down=%b row=%b code=%h, required 0 1011 9",
               key_down, row, key_code);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (row !== 4'b0111) begin
      failures++;
      $display("FAIL glitch_resume: row=%b, required 0111", row);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int start;
    start = pulse_count;
    wait_row_fresh(4'b1011);
    keys[2][1] = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    keys[2][1] = 1'b0;
    #1;
    tests_run++;
    if (row !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: row=%b code=%h valid=%b down=%b, required 1110 0 0 0",
               row, key_code, key_valid, key_down);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_valid: key_valid=%b, required 0", key_valid);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (pulse_count != start || key_down !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_event: pulses=%0d down=%b, required 0 0", pulse_count - start, key_down);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    rst = 1'b1;
    test_reset();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_release_glitch();
    test_reset_mid_debounce();
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d events outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
